// File: rtl/fetch_pkg.sv
// Shared definitions for the LEGv8 instruction-fetch stage: state encoding,
// special instruction words and the saturating fetch counter helper.
package fetch_pkg;

   localparam int ADDR_W_DEFAULT = 64;

   // ADDI X31,X31,#0 -- the decoder treats it as a non-writing ADDI, so it is
   // a safe filler for squashed or not-yet-fetched IF/ID slots.
   localparam logic [31:0] NOP    = 32'h910003FF;

   // Unconditional branch with a zero offset; used as the program's halt idiom.
   localparam logic [31:0] B_SELF = 32'h14000000;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   // Increment that sticks at all-ones instead of wrapping back to zero.
   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      if (value == 32'hFFFF_FFFF) begin
         return value;
      end
      return value + 32'd1;
   endfunction

endpackage

// File: rtl/br_target_calc.sv
// Branch target adder: picks the imm26 or imm19 field, sign-extends it to the
// address width, scales it to a byte offset and adds it to the branch's PC.
module br_target_calc #(
   parameter int ADDR_W = 64
) (
   input  logic [25:0]       imm_field,
   input  logic [ADDR_W-1:0] base_pc,
   input  logic              UncondBr,
   output logic [ADDR_W-1:0] target
);

   logic [ADDR_W-1:0] offset;

   // Select and sign-extend the offset field, then scale by 4 and add; any
   // overflow wraps silently modulo 2^ADDR_W.
   always_comb begin
      offset = '0;
      if (UncondBr) begin
         offset = {{(ADDR_W-26){imm_field[25]}}, imm_field[25:0]};
      end else begin
         offset = {{(ADDR_W-19){imm_field[23]}}, imm_field[23:5]};
      end
      target = base_pc + (offset << 2);
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address,
// holds the IF/ID register and handles stall, taken-branch squash and halt.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEFAULT,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   input  logic              stall,
   input  logic              BrTaken,
   input  logic              UncondBr,
   output logic [31:0]       id_instr,
   output logic [ADDR_W-1:0] id_pc,
   output logic              id_valid,
   output logic              halted,
   output logic [31:0]       fetch_count
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] br_target;
   logic              take_branch;
   logic              halt_hit;

   assign imem_addr = pc;

   // Target math only sees the registered IF/ID contents, never imem_data,
   // so there is no path from this block back into the control decode.
   br_target_calc #(
      .ADDR_W(ADDR_W)
   ) u_br_target_calc (
      .imm_field(id_instr[25:0]),
      .base_pc  (id_pc),
      .UncondBr (UncondBr),
      .target   (br_target)
   );

   // A branch only counts when it comes from a real instruction; a taken
   // unconditional branch-to-self is how the program asks to stop.
   always_comb begin
      take_branch = BrTaken && id_valid;
      halt_hit    = take_branch && UncondBr && (id_instr == B_SELF);
   end

   // Main fetch state machine: BOOT primes IF/ID once, RUN advances or
   // redirects the PC, HALT freezes everything until the next reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         id_instr    <= NOP;
         id_pc       <= '0;
         id_valid    <= 1'b0;
         halted      <= 1'b0;
         fetch_count <= '0;
      end else begin
         case (state)
            BOOT: begin
               id_instr    <= imem_data;
               id_pc       <= pc;
               id_valid    <= 1'b1;
               fetch_count <= sat_inc(fetch_count);
               state       <= RUN;
            end
            RUN: begin
               if (stall) begin
                  state <= RUN;
               end else if (halt_hit) begin
                  pc       <= id_pc;
                  id_instr <= NOP;
                  id_valid <= 1'b0;
                  halted   <= 1'b1;
                  state    <= HALT;
               end else if (take_branch) begin
                  pc       <= br_target;
                  id_instr <= NOP;
                  id_valid <= 1'b0;
               end else begin
                  pc          <= pc + ADDR_W'(4);
                  id_instr    <= imem_data;
                  id_pc       <= pc;
                  id_valid    <= 1'b1;
                  fetch_count <= sat_inc(fetch_count);
               end
            end
            HALT: begin
               id_valid <= 1'b0;
               halted   <= 1'b1;
            end
            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the LEGv8 pipeline, directly upstream of the instruction decoder/control block. Owns the program counter, drives the instruction-memory address, computes branch targets from the decoded instruction and the control block's BrTaken/UncondBr, and holds the IF/ID pipeline register that supplies the 32-bit instruction word to control. Handles stall, branch squash, and halt on a self-loop branch.

## Interface
- ADDR_W, 64, PC and address width
- RESET_PC, 0, PC value loaded on reset
- clk  input  1  rising-edge clock; the block's only clock
- reset  input  1  asynchronous, active-low reset
- imem_addr  output  ADDR_W  instruction-memory address; equals pc
- imem_data  input  32  instruction word at imem_addr, valid in the same cycle
- stall  input  1  hazard hold: freeze pc and the IF/ID register
- BrTaken  input  1  from control: the instruction in ID branches
- UncondBr  input  1  from control: 1 selects the imm26 offset, 0 selects the imm19 offset
- id_instr  output  32  IF/ID instruction fed to control
- id_pc  output  ADDR_W  PC of id_instr
- id_valid  output  1  id_instr is a real fetched instruction, not a bubble
- halted  output  1  block is in HALT
- fetch_count  output  32  saturating count of instructions accepted into IF/ID

## Operation
- FSM states: BOOT, RUN, HALT.
- Reset (asynchronous, reset=0): state=BOOT, pc=RESET_PC, id_instr=NOP, id_pc=0, id_valid=0, halted=0, fetch_count=0.
- BOOT: lasts exactly one cycle after reset release. pc holds. The IF/ID register loads imem_data as a valid instruction. Next state is RUN.
- RUN, priority high to low:
  - stall=1: pc, IF/ID and fetch_count hold. BrTaken is ignored.
  - BrTaken=1 with id_valid=1: pc<=target. IF/ID loads a bubble (NOP, id_valid=0) that squashes the wrong-path fetch. fetch_count holds.
  - Otherwise: pc<=pc+4. IF/ID loads imem_data and pc, with id_valid=1. fetch_count increments.
- Branch target: offset is SignExt(id_instr[25:0]) when UncondBr=1, else SignExt(id_instr[23:5]). The offset is sign-extended to ADDR_W and shifted left by 2, then target = id_pc + offset. Arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- BrTaken=1 while id_valid=0 is ignored; bubbles never branch.
- HALT entry: in RUN with stall=0, BrTaken=1, UncondBr=1, and id_instr==B_SELF (offset 0). The branch target equals id_pc. pc<=id_pc, IF/ID loads a bubble, and the state goes to HALT.
- HALT: pc and IF/ID frozen with id_valid=0. halted=1. Only reset exits HALT.
- fetch_count saturates at 32'hFFFF_FFFF.

## Timing
- imem_addr is combinational from the pc register, and imem_data is sampled in the same cycle. Fetch-to-ID latency is 1 cycle.
- Taken-branch penalty is 1 bubble. The target instruction reaches id_instr 2 cycles after the branch is in ID.
- BrTaken and UncondBr are combinational functions of id_instr, so the block must not feed id_instr back into any path that reaches BrTaken. Target computation uses registered id_instr and id_pc only.
- stall takes effect at the next rising edge. Outputs are stable for the whole stall.
- halted asserts in the cycle after the halting edge.
- Reset asserted mid-operation forces the reset values immediately, without waiting for the clock, including from HALT.

## Structure
- Shared package fetch_pkg:
  - NOP = 32'h910003FF (ADDI X31,X31,#0), which the decoder handles as a non-writing ADDI
  - B_SELF = 32'h14000000
  - state enum {BOOT, RUN, HALT}
  - ADDR_W default
- One sub-module: br_target_calc (combinational sign-extend, shift and add). Everything else stays in fetch_unit.

## Test plan
- Reset, then release with memory holding sequential ADDI at 0,4,8 -> imem_addr 0,4,8,… ; id_instr reaches word@0 one cycle after BOOT; id_valid=1; fetch_count counts 1,2,3.
- B +3 (0x14000003) at pc 8, control drives BrTaken=1/UncondBr=1 -> next pc=20; one bubble (id_instr=NOP, id_valid=0); word@20 appears in ID next.
- CBZ with imm19=-2 at pc 0x40, BrTaken=1/UncondBr=0 -> pc=0x38; fetch_count not incremented for the bubble.
- stall=1 for 3 cycles with BrTaken=1 asserted -> pc, id_instr and fetch_count unchanged throughout; the branch is taken on the first unstalled cycle.
- B_SELF at pc 0x10 -> halted=1 next cycle; pc stays 0x10; id_valid stays 0 for 10+ cycles; reset pulse -> pc=RESET_PC, halted=0.
- reset asserted asynchronously between edges mid-RUN -> all outputs take their reset values before the next rising edge.
